// File: rtl/rv32i_fetch_ctrl_pkg.sv
// Shared definitions for the RV32I fetch controller.
//   fetch_state_e    : fetch FSM state encoding
//   NOP_INSTR        : canonical NOP (addi x0,x0,0) held in IF/ID while empty
//   DEFAULT_RESET_PC : default PC loaded on reset
//   PC_STEP          : sequential PC increment
//   is_aligned()     : true when an address is 4-byte aligned
package rv32i_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_KILL = 2'd2,
    FETCH_TRAP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_fetch_ctrl_flush.sv
// Flush pulse generator: holds flush_o high for FLUSH_CYCLES cycles starting
// the cycle after start_i, restarting the count on every start_i.
//   clk, rst : clock, synchronous active-high reset
//   start_i  : redirect accepted this cycle
//   flush_o  : flush pulse to decode
// FLUSH_CYCLES is expected in 1..3 (2-bit counter).
module rv32i_flush_timer #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic flush_o
);

  localparam logic [1:0] LOAD_VAL = 2'(FLUSH_CYCLES);

  logic [1:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (start_i) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign flush_o = (cnt_q != 2'd0);

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I PC sequencer / fetch controller.
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req/imem_addr          : fetch request, held with stable address
//   imem_ready/imem_rdata       : transfer when req && ready, data same cycle
//   stall                       : decode cannot take a new instruction
//   ex_valid/ex_pc_taken/ex_pc_next : redirect from the EX branch unit
//   if_valid/if_instr/if_pc     : IF/ID output register
//   flush_id                    : kill decode contents after a redirect
//   trap_misalign/trap_pc       : sticky misaligned-target trap
module rv32i_fetch_ctrl
  import rv32i_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_pc_taken,
  input  logic [31:0] ex_pc_next,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush_id,
  output logic        trap_misalign,
  output logic [31:0] trap_pc
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  kill_addr_q;  // address of the wrong-path request still in flight
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic         trap_q;
  logic [31:0]  trap_pc_q;

  logic redir;
  logic trap_hit;
  logic redir_ok;
  logic xfer;

  assign redir    = ex_valid && ex_pc_taken && !trap_q;
  assign trap_hit = redir && !is_aligned(ex_pc_next);
  assign redir_ok = redir && is_aligned(ex_pc_next);

  // The request must react to stall in the same cycle, so it is decoded from
  // state rather than registered. In KILL the old address is replayed so an
  // outstanding handshake is never changed mid-request.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH_REQ:  imem_req = !(if_valid_q && stall);
      FETCH_KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
      end
      default: ;
    endcase
  end

  assign xfer = imem_req && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= 32'd0;
      trap_q      <= 1'b0;
      trap_pc_q   <= 32'd0;
    end else if (trap_hit) begin
      trap_q     <= 1'b1;
      trap_pc_q  <= ex_pc_next;
      if_valid_q <= 1'b0;
      state_q    <= FETCH_TRAP;
    end else if (redir_ok) begin
      // Redirect wins over stall; any word arriving this cycle is wrong-path.
      pc_q       <= ex_pc_next;
      if_valid_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_REQ;
        FETCH_REQ: begin
          if (imem_req && !imem_ready) begin
            state_q     <= FETCH_KILL;
            kill_addr_q <= pc_q;
          end
        end
        FETCH_KILL: begin
          if (xfer) state_q <= FETCH_REQ;
        end
        default: ;
      endcase
    end else begin
      if (if_valid_q && !stall) if_valid_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: state_q <= FETCH_REQ;
        FETCH_REQ: begin
          // A transfer only happens when the register is empty or draining,
          // so this load never overwrites a held instruction.
          if (xfer) begin
            if_instr_q <= imem_rdata;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + PC_STEP;
          end
        end
        FETCH_KILL: begin
          if (xfer) state_q <= FETCH_REQ;
        end
        default: if_valid_q <= 1'b0;
      endcase
    end
  end

  rv32i_flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (redir_ok),
    .flush_o (flush_id)
  );

  assign if_valid      = if_valid_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;
  assign trap_misalign = trap_q;
  assign trap_pc       = trap_pc_q;

endmodule
